// File: rtl/display_scan_controller_if.sv
// Display scan bus: digit data and control toward the scanner, decoder/enable drive back out.
interface display_scan_controller_if #(
    parameter int NUM_DIGITS = 6
);
    logic                    en;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   alpha;
    logic [NUM_DIGITS-1:0]   blink;
    logic [3:0]              value;
    logic                    mode;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    frame_start;

    modport master (
        output en, digits, alpha, blink,
        input  value, mode, digit_en, frame_start
    );

    modport slave (
        input  en, digits, alpha, blink,
        output value, mode, digit_en, frame_start
    );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexed seven-segment scan: per-slot blanking guard, blink suppression,
// and a per-frame snapshot of the digit data.
//
// state   | meaning
// S_IDLE  | scanning stopped, all digits dark, value/mode held
// S_BLANK | start of slot, decoder fed, digit dark (anti-ghosting guard)
// S_DRIVE | rest of slot, current digit lit unless blinked off
module display_scan_controller #(
    parameter int NUM_DIGITS   = 6,
    parameter int DIV          = 1000,
    parameter int BLANK        = 16,
    parameter int BLINK_FRAMES = 50
) (
    input  logic                      clk,
    input  logic                      reset,
    display_scan_controller_if.slave  bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FCNT_LAST  = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           idx, idx_n;
    logic [FW-1:0]           fcnt, fcnt_n;
    logic                    blink_phase, blink_phase_n;
    logic [4*NUM_DIGITS-1:0] snap_digits, snap_digits_n;
    logic [NUM_DIGITS-1:0]   snap_alpha, snap_alpha_n;
    logic [NUM_DIGITS-1:0]   snap_blink, snap_blink_n;
    logic [3:0]              value_q, value_n;
    logic                    mode_q, mode_n;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_n;
    logic                    frame_start_q, frame_start_n;

    state_t slot_entry;
    assign slot_entry = (BLANK == 0) ? S_DRIVE : S_BLANK;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            idx           <= '0;
            fcnt          <= '0;
            blink_phase   <= 1'b0;
            snap_digits   <= '0;
            snap_alpha    <= '0;
            snap_blink    <= '0;
            value_q       <= '0;
            mode_q        <= 1'b0;
            digit_en_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            fcnt          <= fcnt_n;
            blink_phase   <= blink_phase_n;
            snap_digits   <= snap_digits_n;
            snap_alpha    <= snap_alpha_n;
            snap_blink    <= snap_blink_n;
            value_q       <= value_n;
            mode_q        <= mode_n;
            digit_en_q    <= digit_en_n;
            frame_start_q <= frame_start_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        idx_n         = idx;
        fcnt_n        = fcnt;
        blink_phase_n = blink_phase;
        snap_digits_n = snap_digits;
        snap_alpha_n  = snap_alpha;
        snap_blink_n  = snap_blink;
        frame_start_n = 1'b0;
        value_n       = value_q;
        mode_n        = mode_q;
        digit_en_n    = '0;

        if (!bus.en) begin
            state_n       = S_IDLE;
            cnt_n         = '0;
            idx_n         = '0;
            fcnt_n        = '0;
            blink_phase_n = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n       = slot_entry;
                    cnt_n         = '0;
                    idx_n         = '0;
                    snap_digits_n = bus.digits;
                    snap_alpha_n  = bus.alpha;
                    snap_blink_n  = bus.blink;
                    frame_start_n = 1'b1;
                end
                S_BLANK, S_DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        state_n = slot_entry;
                        if (idx == IDX_LAST) begin
                            idx_n         = '0;
                            snap_digits_n = bus.digits;
                            snap_alpha_n  = bus.alpha;
                            snap_blink_n  = bus.blink;
                            frame_start_n = 1'b1;
                            if (fcnt == FCNT_LAST) begin
                                fcnt_n        = '0;
                                blink_phase_n = ~blink_phase;
                            end else begin
                                fcnt_n = fcnt + FW'(1);
                            end
                        end else begin
                            idx_n = idx + IW'(1);
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                        if (state == S_BLANK && cnt == BLANK_LAST)
                            state_n = S_DRIVE;
                    end
                end
                default: state_n = S_IDLE;
            endcase

            // Decoder inputs follow the slot from its first cycle so segments settle while dark.
            value_n = snap_digits_n[{idx_n, 2'b00} +: 4];
            mode_n  = snap_alpha_n[idx_n];
            if (state_n == S_DRIVE && !(blink_phase_n && snap_blink_n[idx_n]))
                digit_en_n = NUM_DIGITS'(1) << idx_n;
        end
    end

    assign bus.value       = value_q;
    assign bus.mode        = mode_q;
    assign bus.digit_en    = digit_en_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed scenarios plus random input churn,
// every cycle compared against a time-based reference model.
module tb_display_scan_controller;
    localparam int N     = 6;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int BF    = 2;
    localparam int FRAME = N * DIV;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    display_scan_controller_if #(.NUM_DIGITS(N)) bus();

    display_scan_controller #(
        .NUM_DIGITS(N), .DIV(DIV), .BLANK(BLANK), .BLINK_FRAMES(BF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: t = cycles since the enabling edge; everything else follows by division.
    bit        m_active;
    int        m_t;
    int        m_d [N];
    bit        m_a [N];
    bit        m_b [N];
    logic [3:0]   exp_value;
    logic         exp_mode;
    logic [N-1:0] exp_en;
    logic         exp_fs;

    always @(posedge clk or posedge reset) begin
        int nt, slot, pos, d, frame, ph, cd;
        bit fs, ca, cb;
        if (reset) begin
            m_active  <= 1'b0;
            m_t       <= 0;
            exp_value <= '0;
            exp_mode  <= 1'b0;
            exp_en    <= '0;
            exp_fs    <= 1'b0;
        end else if (!bus.en) begin
            m_active <= 1'b0;
            exp_en   <= '0;
            exp_fs   <= 1'b0;
        end else begin
            nt    = m_active ? m_t + 1 : 0;
            fs    = (nt % FRAME) == 0;
            slot  = nt / DIV;
            pos   = nt % DIV;
            d     = slot % N;
            frame = slot / N;
            ph    = (frame / BF) % 2;
            if (fs) begin
                for (int i = 0; i < N; i++) begin
                    m_d[i] <= int'(bus.digits[4*i +: 4]);
                    m_a[i] <= bus.alpha[i];
                    m_b[i] <= bus.blink[i];
                end
                cd = int'(bus.digits[4*d +: 4]);
                ca = bus.alpha[d];
                cb = bus.blink[d];
            end else begin
                cd = m_d[d];
                ca = m_a[d];
                cb = m_b[d];
            end
            m_active  <= 1'b1;
            m_t       <= nt;
            exp_value <= 4'(cd);
            exp_mode  <= ca;
            exp_en    <= (pos >= BLANK && !(ph == 1 && cb)) ? N'(1) << d : '0;
            exp_fs    <= fs;
        end
    end

    always @(negedge clk) begin
        chk("value", 32'(bus.value), 32'(exp_value));
        chk("mode", 32'(bus.mode), 32'(exp_mode));
        chk("digit_en", 32'(bus.digit_en), 32'(exp_en));
        chk("frame_start", 32'(bus.frame_start), 32'(exp_fs));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus.en     = 1'b0;
        bus.digits = '0;
        bus.alpha  = '0;
        bus.blink  = '0;
        step(3);
        reset = 1'b0;
        step(2);

        // basic scan, then snapshot change during slot 2 of the third frame
        bus.digits = 24'h543210;
        bus.en     = 1'b1;
        step(96);
        step(20);
        bus.digits = 24'h999999;
        step(80);

        // blink digit 1 over six frames from a fresh start
        bus.digits = 24'h543210;
        bus.blink  = 6'b000010;
        bus.en     = 1'b0;
        step(2);
        bus.en = 1'b1;
        step(6 * FRAME);

        // alphabet mode on digit 5
        bus.blink  = '0;
        bus.alpha  = 6'b100000;
        bus.digits = 24'hB43210;
        step(2 * FRAME);

        // enable drop in slot 3 and re-enable
        bus.en = 1'b0;
        step(1);
        bus.en = 1'b1;
        step(3 * DIV + 5);
        bus.en = 1'b0;
        step(3);
        bus.en = 1'b1;
        step(60);

        // async reset between edges while a digit is lit
        #2;
        reset = 1'b1;
        #1;
        chk("async_digit_en", 32'(bus.digit_en), 32'h0);
        chk("async_value", 32'(bus.value), 32'h0);
        chk("async_mode", 32'(bus.mode), 32'h0);
        chk("async_frame_start", 32'(bus.frame_start), 32'h0);
        step(2);
        reset = 1'b0;
        step(2 * FRAME);

        // random churn
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) bus.digits = 24'($urandom);
            if ($urandom_range(29) == 0) bus.alpha  = 6'($urandom);
            if ($urandom_range(39) == 0) bus.blink  = 6'($urandom);
            if (bus.en && $urandom_range(299) == 0)
                bus.en = 1'b0;
            else if (!bus.en && $urandom_range(3) == 0)
                bus.en = 1'b1;
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexing scan controller for the watch's multi-digit seven-segment display. It shares the single seven-segment decoder across all digit positions. Each slot it presents one digit's 4-bit code and number/alphabet mode to the decoder and drives a one-hot digit enable. Each slot opens with a blanking guard against ghosting, and digits flagged for blinking are suppressed on alternate blink half-periods. Input codes are snapshotted once per frame so a frame never mixes old and new data.

## Interface
- NUM_DIGITS, 6: number of digit positions scanned.
- DIV, 1000: clock cycles per digit slot; DIV >= 2.
- BLANK, 16: blanking cycles at the start of each slot; 0 <= BLANK < DIV.
- BLINK_FRAMES, 50: frames per blink half-period; >= 1.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  scan enable.
- digits  in  4*NUM_DIGITS  digit i code at [4i+3:4i].
- alpha  in  NUM_DIGITS  per-digit decoder mode: 0 number, 1 alphabet.
- blink  in  NUM_DIGITS  per-digit blink request.
- value  out  4  code to the decoder value input.
- mode  out  1  to the decoder mode input.
- digit_en  out  NUM_DIGITS  one-hot active-high digit select.
- frame_start  out  1  one-cycle pulse at the start of each frame.

## Operation
- State: slot counter cnt (clog2(DIV) bits), digit index idx (clog2(NUM_DIGITS) bits), frame counter fcnt (clog2(BLINK_FRAMES) bits), blink_phase, phase FSM, snapshot registers snap_digits, snap_alpha and snap_blink. All outputs are registered.
- FSM states are IDLE, BLANK and DRIVE.
  - IDLE -> BLANK when en = 1. On that edge: cnt = 0, idx = 0, snapshot captured, frame_start = 1.
  - BLANK -> DRIVE when cnt = BLANK-1. If BLANK = 0, the slot enters DRIVE directly.
  - DRIVE -> BLANK when cnt = DIV-1 (next slot).
  - Any state -> IDLE when en = 0.
- Slot advance, on the edge where cnt = DIV-1:
  - cnt -> 0.
  - idx -> idx+1, or 0 when idx = NUM_DIGITS-1.
- Frame wrap, when idx wraps to 0:
  - Snapshot recaptured and frame_start = 1 for that cycle.
  - fcnt increments. When fcnt = BLINK_FRAMES-1 it goes to 0 and blink_phase toggles.
- value and mode come from snap_digits[idx] and snap_alpha[idx] for the whole slot, including blanking, so the decoder settles before the digit lights.
- digit_en:
  - 0 in IDLE and BLANK.
  - In DRIVE it is one-hot(idx), except 0 when blink_phase = 1 and snap_blink[idx] = 1.
- en = 0 mid-frame: on the next edge go to IDLE.
  - digit_en = 0, cnt = idx = fcnt = 0, blink_phase = 0.
  - value and mode hold their last values.
  - Re-enabling starts a fresh frame at slot 0.
- Input changes between frame starts have no effect on the outputs until the next frame_start.

## Timing
- Reset values: value = 0, mode = 0, digit_en = 0, frame_start = 0, and all state and snapshot registers 0 with FSM in IDLE. Reset is asynchronous: outputs clear without a clock edge.
- Latency from en sampled high to frame_start = 1 is one edge. digit_en first asserts BLANK cycles later.
- Slot = DIV cycles: BLANK cycles dark, then DIV-BLANK cycles lit.
- Frame = NUM_DIGITS*DIV cycles. Blink period = 2*BLINK_FRAMES frames.
- digit_en is never multi-hot. It is always 0 on the cycle where idx changes (when BLANK >= 1).
- en falling and a slot boundary on the same edge: IDLE wins.

## Test plan
Parameters for all scenarios: NUM_DIGITS=6, DIV=8, BLANK=2, BLINK_FRAMES=2.

- Basic scan: reset, digits=24'h543210, alpha=0, en=1.
  - frame_start pulses every 48 cycles.
  - Slot 0: digit_en=000000 for 2 cycles, then 000001 for 6 cycles, with value=0 and mode=0.
  - Slot 5: digit_en=100000 with value=5.
- Snapshot: change digits to 24'h999999 during slot 2.
  - Slots 2-5 still show 2,3,4,5.
  - Value 9 appears only after the next frame_start.
- Blink: blink=000010.
  - Frames 0-1 light digit 1.
  - Frames 2-3 never assert digit_en[1]; other digits stay normal.
  - Frames 4-5 light digit 1 again.
- Alphabet mode: alpha=100000, digits[23:20]=4'hB.
  - During slot 5: mode=1, value=4'hB.
  - Slots 0-4: mode=0.
- Enable drop: deassert en in cycle 5 of slot 3.
  - Next edge: digit_en=0.
  - Re-assert en: frame_start=1, then slot 0 follows with its 2 blank cycles.
- Async reset: assert reset mid-DRIVE between clock edges.
  - digit_en, value and mode go to 0 immediately.
  - After release with en=1, a normal frame restarts.
